// File: rtl/input_frame_buffer_pkg.sv
// Shared state encoding and default sizing for the input frame buffer.
package input_frame_buffer_pkg;

    localparam int IFB_DATA_WIDTH = 256;
    localparam int IFB_DEPTH      = 4096;
    localparam int IFB_ADDR_WIDTH = 12;
    localparam int IFB_PASS_WIDTH = 8;
    localparam int IFB_LEN_WIDTH  = IFB_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_RELOAD = 2'd3
    } ifb_state_e;

endpackage

// File: rtl/input_frame_buffer_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sdp_ram
    import input_frame_buffer_pkg::*;
#(
    parameter int WIDTH      = IFB_DATA_WIDTH,
    parameter int DEPTH      = IFB_DEPTH,
    parameter int ADDR_WIDTH = IFB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read register only moves on rd_en, so it holds its word across stalls.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/input_frame_buffer.sv
// Loads one frame from the DMA stream, then replays it a set number of passes.
module input_frame_buffer
    import input_frame_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = IFB_DATA_WIDTH,
    parameter int DEPTH      = IFB_DEPTH,
    parameter int ADDR_WIDTH = IFB_ADDR_WIDTH,
    parameter int PASS_WIDTH = IFB_PASS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] S_Data,
    input  logic                  S_Valid,
    output logic                  S_Ready,
    input  logic                  S_Last,
    input  logic [PASS_WIDTH-1:0] Pass_Num,
    output logic [DATA_WIDTH-1:0] M_Data,
    output logic                  M_Valid,
    input  logic                  M_Ready,
    output logic                  M_Last,
    output logic                  Frame_Done,
    output logic                  Overflow,
    output logic                  Busy
);

    localparam int LEN_WIDTH = ADDR_WIDTH + 1;

    ifb_state_e            state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LEN_WIDTH-1:0]  len;
    logic [PASS_WIDTH-1:0] passes;
    logic [PASS_WIDTH-1:0] rd_pass;
    logic [PASS_WIDTH-1:0] pass_cnt;
    logic                  rd_done;
    logic                  q_valid;
    logic                  q_last;
    logic                  s_ready_q;
    logic                  done_q;
    logic                  ovf_q;

    logic s_beat;
    logic m_beat;
    logic wr_full;
    logic rd_wrap;
    logic issue;
    logic final_beat;

    assign s_beat  = S_Valid && s_ready_q;
    assign m_beat  = q_valid && M_Ready;
    assign wr_full = wr_ptr == ADDR_WIDTH'(DEPTH - 1);
    assign rd_wrap = ({1'b0, rd_ptr} + LEN_WIDTH'(1)) == len;

    // The RAM read register is the head slot; a read refills it only as it drains.
    assign issue = (state == ST_PRIME)
                || (state == ST_STREAM && !rd_done && (!q_valid || m_beat));

    assign final_beat = m_beat && q_last
                     && pass_cnt == passes - PASS_WIDTH'(1);

    sdp_ram #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (s_beat),
        .wr_addr (wr_ptr),
        .wr_data (S_Data),
        .rd_en   (issue),
        .rd_addr (rd_ptr),
        .rd_data (M_Data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_LOAD;
            wr_ptr    <= '0;
            len       <= '0;
            passes    <= '0;
            pass_cnt  <= '0;
            s_ready_q <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_LOAD: begin
                    if (s_beat) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                        if (S_Last || wr_full) begin
                            len       <= {1'b0, wr_ptr} + LEN_WIDTH'(1);
                            passes    <= (Pass_Num == '0) ? PASS_WIDTH'(1) : Pass_Num;
                            s_ready_q <= 1'b0;
                            state     <= ST_PRIME;
                            if (!S_Last) ovf_q <= 1'b1;
                        end
                    end
                end
                ST_PRIME: begin
                    pass_cnt <= '0;
                    state    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (final_beat) begin
                        done_q <= 1'b1;
                        state  <= ST_RELOAD;
                    end else if (m_beat && q_last) begin
                        pass_cnt <= pass_cnt + PASS_WIDTH'(1);
                    end
                end
                ST_RELOAD: begin
                    wr_ptr    <= '0;
                    s_ready_q <= 1'b1;
                    state     <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr  <= '0;
            rd_pass <= '0;
            rd_done <= 1'b0;
            q_valid <= 1'b0;
            q_last  <= 1'b0;
        end else if (state == ST_RELOAD) begin
            rd_ptr  <= '0;
            rd_pass <= '0;
            rd_done <= 1'b0;
        end else if (issue) begin
            q_valid <= 1'b1;
            q_last  <= rd_wrap;
            if (rd_wrap) begin
                rd_ptr  <= '0;
                rd_pass <= rd_pass + PASS_WIDTH'(1);
                rd_done <= rd_pass == passes - PASS_WIDTH'(1);
            end else begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end else if (m_beat) begin
            q_valid <= 1'b0;
            q_last  <= 1'b0;
        end
    end

    assign S_Ready    = s_ready_q;
    assign M_Valid    = q_valid;
    assign M_Last     = q_valid && q_last;
    assign Frame_Done = done_q;
    assign Overflow   = ovf_q;
    assign Busy       = state != ST_LOAD;

endmodule

// File: tb/tb_input_frame_buffer.sv
// Bench for input_frame_buffer: queue model of replay order plus directed frames.
module tb_input_frame_buffer;

    localparam int DW = 32;
    localparam int PW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          fin;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data     [2];
    logic          s_valid    [2];
    logic          s_last     [2];
    logic          m_ready    [2];
    logic [PW-1:0] pass_num   [2];
    logic [DW-1:0] m_data     [2];
    logic          s_ready    [2];
    logic          m_valid    [2];
    logic          m_last     [2];
    logic          frame_done [2];
    logic          overflow   [2];
    logic          busy       [2];

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    int    act      = 0;
    bit    mon_en   = 0;
    bit    tgl      = 0;
    int    beat_cnt = 0;
    int    fd_cnt   = 0;

    always #5 clk = ~clk;

    input_frame_buffer #(
        .DATA_WIDTH (DW), .DEPTH (64), .ADDR_WIDTH (6), .PASS_WIDTH (PW)
    ) u_dut0 (
        .clk (clk), .rst (rst),
        .S_Data (s_data[0]), .S_Valid (s_valid[0]), .S_Ready (s_ready[0]),
        .S_Last (s_last[0]), .Pass_Num (pass_num[0]),
        .M_Data (m_data[0]), .M_Valid (m_valid[0]), .M_Ready (m_ready[0]),
        .M_Last (m_last[0]), .Frame_Done (frame_done[0]),
        .Overflow (overflow[0]), .Busy (busy[0])
    );

    input_frame_buffer #(
        .DATA_WIDTH (DW), .DEPTH (8), .ADDR_WIDTH (3), .PASS_WIDTH (PW)
    ) u_dut1 (
        .clk (clk), .rst (rst),
        .S_Data (s_data[1]), .S_Valid (s_valid[1]), .S_Ready (s_ready[1]),
        .S_Last (s_last[1]), .Pass_Num (pass_num[1]),
        .M_Data (m_data[1]), .M_Valid (m_valid[1]), .M_Ready (m_ready[1]),
        .M_Last (m_last[1]), .Frame_Done (frame_done[1]),
        .Overflow (overflow[1]), .Busy (busy[1])
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Model: the stored frame is min(n, depth) words, replayed max(p,1) times.
    task automatic model_frame(input logic [DW-1:0] base, input int n,
                               input int p, input int depth);
        beat_t b;
        int    len;
        int    np;
        len = (n > depth) ? depth : n;
        np  = (p == 0) ? 1 : p;
        for (int k = 0; k < np; k++) begin
            for (int i = 0; i < len; i++) begin
                b.data = base + DW'(i);
                b.last = (i == len - 1);
                b.fin  = (k == np - 1) && (i == len - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    beat_t         e;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            done_due  = 0;
    int            since_fin = -1;

    always @(negedge clk) begin
        logic          mv, mr, ml, fd, sr;
        logic [DW-1:0] md;
        if (mon_en) begin
            mv = m_valid[act];
            mr = m_ready[act];
            ml = m_last[act];
            fd = frame_done[act];
            sr = s_ready[act];
            md = m_data[act];
            chk("frame_done", 64'(fd), 64'(done_due));
            done_due = 0;
            if (fd) fd_cnt++;
            if (since_fin >= 0) since_fin++;
            if (since_fin == 1) chk("s_ready_reload", 64'(sr), 0);
            if (since_fin == 2) begin
                chk("s_ready_back", 64'(sr), 1);
                since_fin = -1;
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(mv), 1);
                chk("stall_data", 64'(md), 64'(prev_data));
                chk("stall_last", 64'(ml), 64'(prev_last));
            end
            if (mv && mr) begin
                beat_cnt++;
                chk("beat_expected", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("m_data", 64'(md), 64'(e.data));
                    chk("m_last", 64'(ml), 64'(e.last));
                    if (e.fin) begin
                        done_due  = 1;
                        since_fin = 0;
                    end
                end
            end
            prev_stall = mv && !mr;
            prev_data  = md;
            prev_last  = ml;
        end else begin
            prev_stall = 1'b0;
            done_due   = 0;
            since_fin  = -1;
        end
    end

    always @(posedge clk) begin
        if (tgl) begin
            #1;
            m_ready[act] = ~m_ready[act];
        end
    end

    task automatic do_reset();
        mon_en = 0;
        tgl    = 0;
        exp_q.delete();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d]  = 1'b0;
            s_last[d]   = 1'b0;
            s_data[d]   = '0;
            m_ready[d]  = 1'b0;
            pass_num[d] = PW'(1);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        beat_cnt = 0;
        fd_cnt   = 0;
        mon_en   = 1;
    endtask

    task automatic send_word(input int d, input logic [DW-1:0] w,
                             input logic lst, input int budget, output bit ok);
        ok         = 0;
        s_valid[d] = 1'b1;
        s_data[d]  = w;
        s_last[d]  = lst;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (s_ready[d]) begin
                ok = 1;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!ok) begin
            @(posedge clk);
            #1;
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
        s_data[d]  = 'x;
    endtask

    task automatic send_frame(input int d, input logic [DW-1:0] base,
                              input int n, input bit with_last, input int p,
                              input int budget, output int acc);
        bit ok;
        acc         = 0;
        pass_num[d] = PW'(p);
        for (int i = 0; i < n; i++) begin
            send_word(d, base + DW'(i), with_last && (i == n - 1), budget, ok);
            if (ok) acc++;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 600) begin
            @(negedge clk);
            c++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int c;
        int run;

        // Reset state and a 4-word single pass
        act = 0;
        do_reset();
        chk("rst_s_ready", 64'(s_ready[0]), 1);
        chk("rst_m_valid", 64'(m_valid[0]), 0);
        chk("rst_m_last", 64'(m_last[0]), 0);
        chk("rst_frame_done", 64'(frame_done[0]), 0);
        chk("rst_overflow", 64'(overflow[0]), 0);
        chk("rst_busy", 64'(busy[0]), 0);
        m_ready[0] = 1'b1;
        model_frame(32'hA0, 4, 1, 64);
        send_frame(0, 32'hA0, 4, 1, 1, 8, acc);
        chk("t1_accepted", 64'(acc), 4);
        @(negedge clk);
        chk("t1_prime_valid", 64'(m_valid[0]), 0);
        chk("t1_prime_sready", 64'(s_ready[0]), 0);
        chk("t1_prime_busy", 64'(busy[0]), 1);
        @(negedge clk);
        chk("t1_first_valid", 64'(m_valid[0]), 1);
        chk("t1_first_data", 64'(m_data[0]), 64'h A0);
        drain();
        chk("t1_beats", 64'(beat_cnt), 4);
        chk("t1_done_cnt", 64'(fd_cnt), 1);
        chk("t1_sready_end", 64'(s_ready[0]), 1);
        chk("t1_busy_end", 64'(busy[0]), 0);

        // Three passes with M_Ready toggling every cycle
        beat_cnt = 0;
        fd_cnt   = 0;
        model_frame(32'hA0, 4, 3, 64);
        tgl = 1;
        send_frame(0, 32'hA0, 4, 1, 3, 8, acc);
        drain();
        tgl = 0;
        @(posedge clk);
        #1;
        m_ready[0] = 1'b1;
        chk("t2_beats", 64'(beat_cnt), 12);
        chk("t2_done_cnt", 64'(fd_cnt), 1);

        // One-word frame with Pass_Num=0
        beat_cnt = 0;
        fd_cnt   = 0;
        model_frame(32'hB0, 1, 0, 64);
        send_frame(0, 32'hB0, 1, 1, 0, 8, acc);
        drain();
        chk("t3_beats", 64'(beat_cnt), 1);
        chk("t3_done_cnt", 64'(fd_cnt), 1);

        // Reset in the middle of pass 2
        beat_cnt = 0;
        fd_cnt   = 0;
        model_frame(32'hE0, 4, 3, 64);
        send_frame(0, 32'hE0, 4, 1, 3, 8, acc);
        c = 0;
        while (beat_cnt != 6 && c < 100) begin
            @(posedge clk);
            c++;
        end
        chk("t5_reached", 64'(beat_cnt), 6);
        #2;
        mon_en = 0;
        rst    = 1'b0;
        #1;
        chk("t5_async_mvalid", 64'(m_valid[0]), 0);
        chk("t5_async_sready", 64'(s_ready[0]), 1);
        chk("t5_async_busy", 64'(busy[0]), 0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        beat_cnt = 0;
        fd_cnt   = 0;
        mon_en   = 1;
        model_frame(32'hC0, 2, 1, 64);
        send_frame(0, 32'hC0, 2, 1, 1, 8, acc);
        drain();
        chk("t5_beats", 64'(beat_cnt), 2);
        chk("t5_done_cnt", 64'(fd_cnt), 1);

        // Throughput: 64 words x 2 passes, one beat per cycle
        beat_cnt = 0;
        fd_cnt   = 0;
        model_frame(32'h100, 64, 2, 64);
        send_frame(0, 32'h100, 64, 1, 2, 8, acc);
        chk("t6_accepted", 64'(acc), 64);
        c = 0;
        @(negedge clk);
        while (!m_valid[0] && c < 10) begin
            @(negedge clk);
            c++;
        end
        run = 0;
        for (int i = 0; i < 128; i++) begin
            if (m_valid[0] && m_ready[0]) run++;
            @(negedge clk);
        end
        chk("t6_run", 64'(run), 128);
        chk("t6_after_valid", 64'(m_valid[0]), 0);
        drain();
        chk("t6_beats", 64'(beat_cnt), 128);
        chk("t6_done_cnt", 64'(fd_cnt), 1);

        // DEPTH=8 build: 10 words offered without S_Last
        act = 1;
        do_reset();
        chk("t4_rst_overflow", 64'(overflow[1]), 0);
        model_frame(32'hD0, 10, 1, 8);
        send_frame(1, 32'hD0, 10, 0, 1, 4, acc);
        chk("t4_accepted", 64'(acc), 8);
        chk("t4_overflow", 64'(overflow[1]), 1);
        chk("t4_sready", 64'(s_ready[1]), 0);
        chk("t4_head_valid", 64'(m_valid[1]), 1);
        m_ready[1] = 1'b1;
        drain();
        chk("t4_beats", 64'(beat_cnt), 8);
        chk("t4_done_cnt", 64'(fd_cnt), 1);
        chk("t4_overflow_sticky", 64'(overflow[1]), 1);
        chk("t4_busy_end", 64'(busy[1]), 0);
        do_reset();
        chk("t4_overflow_cleared", 64'(overflow[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
